// File: rtl/embed_pkg.sv
// Shared widths and FSM encoding for the embedding sign-magnitude packer.
package embed_pkg;

    localparam int unsigned N_ELEM = 10;
    localparam int unsigned MAG_W  = 4;
    localparam int unsigned ELEM_W = MAG_W + 1;
    localparam int unsigned CNT_W  = $clog2(N_ELEM + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/elem_sm_encode.sv
// Two's-complement to sign-magnitude lane encoder; the most negative code clamps.
module elem_sm_encode #(
    parameter int unsigned MAG_W = embed_pkg::MAG_W
) (
    input  logic [MAG_W:0]   i_elem,
    output logic             o_sign,
    output logic [MAG_W-1:0] o_mag,
    output logic             o_sat
);

    always_comb begin
        o_sign = i_elem[MAG_W];
        o_sat  = (i_elem == {1'b1, {MAG_W{1'b0}}});
        if (o_sat) begin
            o_mag = '1;
        end else if (o_sign) begin
            o_mag = ~i_elem[MAG_W-1:0] + MAG_W'(1);
        end else begin
            o_mag = i_elem[MAG_W-1:0];
        end
    end

endmodule

// File: rtl/embedding_packer.sv
// Assembles encoded elements into sign-magnitude frames and holds each completed
// frame in an output register with its own valid/ready handshake.
module embedding_packer #(
    parameter int unsigned  N_ELEM = embed_pkg::N_ELEM,
    parameter int unsigned  MAG_W  = embed_pkg::MAG_W,
    localparam int unsigned CNT_W  = $clog2(N_ELEM + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAG_W:0]          in_elem,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_ELEM*MAG_W-1:0] out_mag,
    output logic [N_ELEM-1:0]       out_sign,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat
);

    embed_pkg::state_e       r_state;
    logic [CNT_W-1:0]        r_idx;
    logic [N_ELEM*MAG_W-1:0] r_asm_mag;
    logic [N_ELEM-1:0]       r_asm_sign;
    logic                    r_asm_sat;

    logic                    r_out_valid;
    logic [N_ELEM*MAG_W-1:0] r_out_mag;
    logic [N_ELEM-1:0]       r_out_sign;
    logic [CNT_W-1:0]        r_out_count;
    logic                    r_out_sat;

    logic                    w_enc_sign;
    logic [MAG_W-1:0]        w_enc_mag;
    logic                    w_enc_sat;
    logic [N_ELEM*MAG_W-1:0] w_frm_mag;
    logic [N_ELEM-1:0]       w_frm_sign;
    logic                    w_frm_sat;
    logic [CNT_W-1:0]        w_frm_cnt;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_load_fill;
    logic                    w_load_hold;

    elem_sm_encode #(
        .MAG_W (MAG_W)
    ) u_encode (
        .i_elem (in_elem),
        .o_sign (w_enc_sign),
        .o_mag  (w_enc_mag),
        .o_sat  (w_enc_sat)
    );

    assign in_ready    = (r_state == embed_pkg::FILL);
    assign w_accept    = in_valid && in_ready;
    assign w_complete  = w_accept && (in_last || (r_idx == CNT_W'(N_ELEM - 1)));
    assign w_load_fill = w_complete && (!r_out_valid || out_ready);
    assign w_load_hold = (r_state == embed_pkg::HOLD) && out_ready;

    // Assembly with the current element merged into lane r_idx.
    always_comb begin
        w_frm_mag  = r_asm_mag;
        w_frm_sign = r_asm_sign;
        for (int i = 0; i < int'(N_ELEM); i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_frm_mag[MAG_W*i +: MAG_W] = w_enc_mag;
                w_frm_sign[i]               = w_enc_sign;
            end
        end
        w_frm_sat = r_asm_sat | w_enc_sat;
        w_frm_cnt = r_idx + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= embed_pkg::FILL;
            r_idx       <= '0;
            r_asm_mag   <= '0;
            r_asm_sign  <= '0;
            r_asm_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mag   <= '0;
            r_out_sign  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            unique case (r_state)
                embed_pkg::FILL: begin
                    if (w_load_fill) begin
                        r_idx      <= '0;
                        r_asm_mag  <= '0;
                        r_asm_sign <= '0;
                        r_asm_sat  <= 1'b0;
                    end else if (w_accept) begin
                        r_idx      <= w_frm_cnt;
                        r_asm_mag  <= w_frm_mag;
                        r_asm_sign <= w_frm_sign;
                        r_asm_sat  <= w_frm_sat;
                        if (w_complete) begin
                            r_state <= embed_pkg::HOLD;
                        end
                    end
                end
                embed_pkg::HOLD: begin
                    if (out_ready) begin
                        r_state    <= embed_pkg::FILL;
                        r_idx      <= '0;
                        r_asm_mag  <= '0;
                        r_asm_sign <= '0;
                        r_asm_sat  <= 1'b0;
                    end
                end
                default: r_state <= embed_pkg::FILL;
            endcase

            // A held frame (HOLD) and a freshly completed frame (FILL) never load together.
            if (w_load_fill || w_load_hold) begin
                r_out_valid <= 1'b1;
                r_out_mag   <= w_load_hold ? r_asm_mag  : w_frm_mag;
                r_out_sign  <= w_load_hold ? r_asm_sign : w_frm_sign;
                r_out_count <= w_load_hold ? r_idx      : w_frm_cnt;
                r_out_sat   <= w_load_hold ? r_asm_sat  : w_frm_sat;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_mag   = r_out_mag;
    assign out_sign  = r_out_sign;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_embedding_packer.sv
// Self-checking bench for embedding_packer: directed scenarios plus a randomized
// stream scored against a frame-level reference model.
module tb_embedding_packer;

    typedef struct packed {
        logic [39:0] mag;
        logic [9:0]  sign;
        logic [3:0]  cnt;
        logic        sat;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_elem = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_mag;
    logic [9:0]  out_sign;
    logic [3:0]  out_count;
    logic        out_sat;

    frame_t exp_q[$];
    frame_t obs_q[$];
    frame_t m_cur;
    int     m_cnt;
    int     n_checks;
    int     n_fail;

    embedding_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_elem   (in_elem),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_sign  (out_sign),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    function automatic frame_t dut_frame();
        return {out_mag, out_sign, out_count, out_sat};
    endfunction

    function automatic int rand_elem();
        return int'($urandom_range(0, 31)) - 16;
    endfunction

    // Reference: |v| clamped to 15, sign = v<0, frame closes on last or 10th lane.
    task automatic model_push(input int v, input bit last);
        int mag;
        mag = (v < 0) ? -v : v;
        if (mag > 15) mag = 15;
        m_cur.mag[m_cnt*4 +: 4] = 4'(mag);
        m_cur.sign[m_cnt]       = (v < 0);
        if (v == -16) m_cur.sat = 1'b1;
        m_cnt++;
        if (last || m_cnt == 10) begin
            m_cur.cnt = 4'(m_cnt);
            exp_q.push_back(m_cur);
            m_cur = '0;
            m_cnt = 0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        obs_q.delete();
        m_cur = '0;
        m_cnt = 0;
    endtask

    task automatic drive(input int v, input bit last);
        in_valid = 1'b1;
        in_elem  = 5'(v);
        in_last  = last;
    endtask

    // One clock: records handshakes on both sides, then advances to 1 time unit past the edge.
    task automatic tick();
        bit acc;
        int v;
        bit l;
        acc = in_valid && in_ready;
        v   = $signed(in_elem);
        l   = in_last;
        if (out_valid && out_ready) obs_q.push_back(dut_frame());
        @(posedge clk);
        #1;
        if (acc) model_push(v, l);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, expected 0", out_valid);
        end
        n_checks++;
        if (dut_frame() !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h, expected 0", dut_frame());
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_known_frame();
        int          vals[10] = '{3, -2, 0, 7, -8, 15, -15, 1, -1, 4};
        int          mags[10] = '{3, 2, 0, 7, 8, 15, 15, 1, 1, 4};
        logic [39:0] exp_mag;
        model_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vals[i], 1'b0);
            tick();
            if (i == 8) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL known_early: out_valid got %b after 9 accepts, expected 0",
                             out_valid);
                end
            end
        end
        in_valid = 1'b0;
        exp_mag = '0;
        for (int i = 0; i < 10; i++) exp_mag[i*4 +: 4] = 4'(mags[i]);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL known_valid: got %b, expected 1", out_valid);
        end
        n_checks++;
        if (out_sign !== 10'b0101010010) begin
            n_fail++;
            $display("FAIL known_sign: got %b, expected 0101010010", out_sign);
        end
        n_checks++;
        if (out_mag !== exp_mag) begin
            n_fail++;
            $display("FAIL known_mag: got %h, expected %h", out_mag, exp_mag);
        end
        n_checks++;
        if (out_count !== 4'd10 || out_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL known_cnt_sat: got %0d/%b, expected 10/0", out_count, out_sat);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL known_drain: out_valid got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_sat_last();
        model_clear();
        out_ready = 1'b1;
        drive(-16, 1'b0);
        tick();
        drive(5, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_mag !== 40'h5f || out_sign !== 10'h001) begin
            n_fail++;
            $display("FAIL sat_lanes: got v=%b mag=%h sign=%b, expected v=1 mag=5f sign=1",
                     out_valid, out_mag, out_sign);
        end
        n_checks++;
        if (out_count !== 4'd2 || out_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_cnt_sat: got %0d/%b, expected 2/1", out_count, out_sat);
        end
        tick();
    endtask

    task automatic test_hold();
        frame_t f1;
        model_clear();
        out_ready = 1'b0;
        f1 = '0;
        for (int i = 1; i <= 20; i++) begin
            drive(rand_elem(), 1'b0);
            tick();
            if (i == 10) f1 = dut_frame();
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_state: got ready=%b valid=%b, expected ready=0 valid=1",
                     in_ready, out_valid);
        end
        n_checks++;
        if (exp_q.size() != 2 || f1 !== exp_q[0]) begin
            n_fail++;
            $display("FAIL hold_frame1: got %h, expected %h", f1, exp_q[0]);
        end
        repeat (3) tick();
        n_checks++;
        if (in_ready !== 1'b0 || dut_frame() !== f1) begin
            n_fail++;
            $display("FAIL hold_stable: got ready=%b frame=%h, expected ready=0 frame=%h",
                     in_ready, dut_frame(), f1);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got ready=%b valid=%b, expected 1/1",
                     in_ready, out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_drain: out_valid got %b, expected 0", out_valid);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL hold_nframes: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL hold_frame[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        model_clear();
        out_ready = 1'b1;
        bad = 0;
        for (int k = 1; k <= 30; k++) begin
            drive(rand_elem(), 1'b0);
            if (in_ready !== 1'b1) bad++;
            tick();
            if (out_valid !== 1'((k % 10) == 0)) bad++;
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_timing: got %0d bad cycles, expected 0", bad);
        end
        n_checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_nframes: got %0d, expected 3 (model %0d)",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_frame[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        model_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(rand_elem(), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dut_frame() !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_zero: got v=%b frame=%h rdy=%b, expected 0/0/1",
                     out_valid, dut_frame(), in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(rand_elem(), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL rstmid_nframes: got %0d, expected 1", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_frame: got %h, expected %h", obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        model_clear();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_elem   = 5'(rand_elem());
            in_last   = ($urandom_range(0, 9) < 2);
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        out_ready = 1'b1;
        drive(rand_elem(), 1'b1);
        for (int k = 0; k < 20 && m_cnt != 0; k++) tick();
        n_checks++;
        if (m_cnt != 0) begin
            n_fail++;
            $display("FAIL rand_close: timed out with %0d lanes pending, expected 0", m_cnt);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_nframes: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_frame[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        test_reset();
        test_known_frame();
        test_sat_last();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
